display_bcd_2d: RTL
===================

# display_bcd_2d

Two-digit multiplexed 7-segment display driver for the 00–99 BCD counter outputs: units digit (M) and tens digit (S). It time-multiplexes both digits onto one shared segment bus and captures the inputs once per refresh frame, so the display never shows a torn value. It also supports tens-digit leading-zero blanking, whole-display blinking for the "at limit / auto-refill" indication, and flags invalid BCD codes. It sits between the counter and the board's common-anode display pins.

## Interface
- SCAN_DIV, default 50000: clock cycles each digit stays lit (1 ms at 50 MHz); minimum 2.
- BLINK_DIV, default 250: frames per blink half-period (0.5 s at defaults); minimum 1.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- M  input  4  units BCD digit.
- S  input  4  tens BCD digit.
- blank_zero  input  1  blank the tens digit when its captured value is 0.
- blink_en  input  1  enable whole-display blinking.
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- dig  output  2  digit enables, active-low, registered; dig[0] = units, dig[1] = tens.
- err  output  1  registered; high while either captured digit is greater than 9.

## Operation
- div_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and generates a tick.
- Each tick toggles slot: 0 = units, 1 = tens. A tick while slot = 1 is the frame end.
- At frame end:
  - M and S are captured into m_q and s_q.
  - blink_cnt advances. When it wraps at BLINK_DIV-1, blink_phase toggles (1 = on).
- While blink_en = 0, blink_cnt is held at 0 and blink_phase at 1. Enabling blink therefore always starts with a full on half-period.
- Output registers are loaded every cycle from the current slot and the captured digits:
  - Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10–15 show a dash, 0111111.
  - The selected digit is driven low on dig and its pattern is driven on seg.
  - Blank conditions:
    - blink_en = 1 and blink_phase = 0: both digits blank.
    - slot = 1, blank_zero = 1 and s_q = 0: tens digit blank.
  - When blank, dig = 2'b11 and seg = 7'b1111111.
- err is loaded each cycle with (m_q > 9) || (s_q > 9).
- Ports are sampled only at frame end. Changes to M and S mid-frame are invisible until the next frame. blank_zero and blink_en take effect on the next output load.

## Timing
- Reset values:
  - div_cnt = 0, slot = 0, m_q = s_q = 0, blink_cnt = 0, blink_phase = 1.
  - seg = 7'b1111111, dig = 2'b11, err = 0.
- Reset applies on the edge where it is sampled high, including mid-frame and mid-blink. No partial state survives.
- First cycle after reset release: outputs still at reset values. Second cycle: seg = 1000000, dig = 2'b10 (units showing captured 0).
- Output latency: one cycle from a slot or control change to seg and dig.
- Input-to-display latency: at most 2*SCAN_DIV + 1 cycles.
- dig changes on the same edge as seg. At no time are both dig bits low.
- Blink half-period is exactly 2*SCAN_DIV*BLINK_DIV cycles.
- Dropping blink_en during an off phase lights the display two edges later: phase forced on, then outputs loaded.

## Structure
- Put the 7-segment pattern constants (0–9, dash, all-off) in the shared constants include so other display blocks reuse them.
- Implement one combinational sub-module, bcd_7seg: 4-bit BCD in, 7-bit active-low pattern out, dash for 10–15.
- All counters, capture registers and output registers live in display_bcd_2d.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=2 (8-cycle frame).
- Reset, then release -> seg=1111111, dig=11, err=0 for one cycle; then seg=1000000, dig=10; tens slot 4 cycles later shows 1000000 with dig=01.
- M=7, S=4 held across a frame end -> units slot seg=1111000, dig=10; tens slot seg=0011001, dig=01. A mid-frame change to M=2 is not shown until the next frame.
- blank_zero=1, M=3, S=0 -> units seg=0110000, dig=10; tens slot seg=1111111, dig=11. With S=5 the tens slot shows 0010010.
- M=12 captured -> units seg=0111111, err=1. M=6 at the next frame end -> seg=0000010 and err=0 one cycle after capture.
- blink_en=1 with M=1, S=1 -> 16 cycles lit, then 16 cycles dig=11. Dropping blink_en during the off phase -> lit two edges later.
- Reset asserted mid-frame with M=9, S=9 displayed -> next edge seg=1111111, dig=11, err=0. After release the display shows 00 until the first frame end, then 99.

Source files
------------

// File: rtl/display_bcd_2d_pkg.sv
// Shared 7-segment constants and slot encoding for the multiplexed display blocks.
// Patterns are {g,f,e,d,c,b,a}, active-low, for common-anode parts.
package display_bcd_2d_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;
    localparam logic [1:0] DIG_OFF   = 2'b11;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_t;

endpackage

// File: rtl/display_bcd_2d_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 render as a dash.
module bcd_7seg
    import display_bcd_2d_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_bcd_2d.sv
// Two-digit multiplexed 7-segment driver: frame-synchronous capture of M/S,
// tens leading-zero blanking, whole-display blink and invalid-BCD flag.
module display_bcd_2d
    import display_bcd_2d_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] M,
    input  logic [3:0] S,
    input  logic       blank_zero,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       err
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    slot_t            slot;
    logic             blink_phase;
    logic [3:0]       m_q;
    logic [3:0]       s_q;

    logic             tick;
    logic             frame_end;
    logic [3:0]       sel_digit;
    logic [6:0]       sel_pattern;
    logic             blank;
    logic [6:0]       seg_next;
    logic [1:0]       dig_next;

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (slot == SLOT_TENS);
    assign sel_digit = (slot == SLOT_TENS) ? s_q : m_q;

    bcd_7seg u_dec (
        .bcd     (sel_digit),
        .pattern (sel_pattern)
    );

    // blink_phase is only ever 0 while blinking was enabled, so testing the
    // phase alone keeps the display dark for the edge that forces it back on.
    always_comb begin
        blank    = !blink_phase ||
                   ((slot == SLOT_TENS) && blank_zero && (s_q == 4'd0));
        seg_next = blank ? SEG_OFF : sel_pattern;
        dig_next = blank ? DIG_OFF : ((slot == SLOT_TENS) ? DIG_TENS : DIG_UNITS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= '0;
            slot        <= SLOT_UNITS;
            m_q         <= 4'd0;
            s_q         <= 4'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            seg         <= SEG_OFF;
            dig         <= DIG_OFF;
            err         <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                slot    <= (slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (frame_end) begin
                m_q <= M;
                s_q <= S;
            end

            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (frame_end) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            seg <= seg_next;
            dig <= dig_next;
            err <= (m_q > 4'd9) || (s_q > 4'd9);
        end
    end

endmodule
